// File: rtl/imem_wide_arbiter.sv
// imem_wide_arbiter
//
// Shares one wide instruction-memory read port (NUM_BLOCKS x 32-bit lines)
// between two line-fill requesters. Port 0 is the icache refill path. Port 1
// is a secondary line reader, such as a dictionary loader or a prefetcher.
// A round-robin grant picks the requester. Only one memory transaction is
// in flight at a time. A watchdog aborts a read that memory never answers.
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   req0_valid/addr     port 0 request; held stable until req0_ready
//   req0_ready/rdata    port 0 one-cycle response pulse and line data
//   req1_*              same as port 0, for port 1
//   mem_valid/addr      request to imem_wide (address latched at grant)
//   mem_ready/rdata     memory completion pulse and line data
//   busy                high whenever the arbiter is not idle
//   err_timeout         sticky watchdog-abort flag, cleared only by reset
module imem_wide_arbiter #(
    parameter int NUM_BLOCKS = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [31:0]              req0_addr,
    output logic                     req0_ready,
    output logic [32*NUM_BLOCKS-1:0] req0_rdata,
    input  logic                     req1_valid,
    input  logic [31:0]              req1_addr,
    output logic                     req1_ready,
    output logic [32*NUM_BLOCKS-1:0] req1_rdata,
    output logic                     mem_valid,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ready,
    input  logic [32*NUM_BLOCKS-1:0] mem_rdata,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int DW = 32 * NUM_BLOCKS;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_valid_q, mem_valid_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic            ready0_q, ready0_d;
    logic            ready1_q, ready1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic            pick;
    logic            resp_fire;
    logic [DW-1:0]   resp_data;
    logic [CW-1:0]   cnt_inc;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        err_d        = err_q;
        pick         = 1'b0;
        resp_fire    = 1'b0;
        resp_data    = '0;
        cnt_inc      = cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the port that was not served last wins;
                    // otherwise the lone requester wins.
                    pick        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    grant_d     = pick;
                    mem_addr_d  = pick ? req1_addr : req0_addr;
                    cnt_d       = '0;
                    mem_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A memory response on the same edge as the watchdog limit
                // takes precedence, so real data is never discarded.
                if (mem_ready) begin
                    resp_fire = 1'b1;
                    resp_data = mem_rdata;
                end else if (TIMEOUT != 0) begin
                    if (cnt_inc == TO_LIMIT) begin
                        resp_fire = 1'b1;
                        resp_data = '0;
                        err_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                if (resp_fire) begin
                    mem_valid_d = 1'b0;
                    state_d     = S_RESP;
                    if (grant_q) begin
                        ready1_d = 1'b1;
                        rdata1_d = resp_data;
                    end else begin
                        ready0_d = 1'b1;
                        rdata0_d = resp_data;
                    end
                end
            end
            S_RESP: begin
                last_grant_d = grant_q;
                state_d      = S_DRAIN;
            end
            S_DRAIN: begin
                // No grant here: the served requester needs one cycle to drop valid.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign req0_ready  = ready0_q;
    assign req1_ready  = ready1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_imem_wide_arbiter.sv
// Testbench for imem_wide_arbiter: a transaction-timestamp model of the
// arbiter, a latency-programmable memory stub and two queue-fed requesters.
module tb_imem_wide_arbiter;

    localparam int NB = 2;
    localparam int TO = 8;
    localparam int DW = 32 * NB;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req_valid [2];
    logic [31:0]   req_addr [2];
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          busy, err_timeout;

    imem_wide_arbiter #(.NUM_BLOCKS(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_addr(req_addr[0]),
        .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req1_valid(req_valid[1]), .req1_addr(req_addr[1]),
        .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .err_timeout(err_timeout)
    );

    // Memory contents: the word at byte address a is 0xA0000000 + a/4.
    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [31:0] w;
        w = 32'hA000_0000 + (a >> 2);
        return {w + 32'd1, w};
    endfunction

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stimulus controls
    int  lat;
    bit  kill;
    bit  force_ready;
    logic [31:0] pq [2][$];
    int          lp [$];
    logic [31:0] la [$];
    logic [63:0] ld [$];

    // Compare-side bookkeeping
    int  runs [$];
    int  gq [$];
    int  r1_cnt;

    // Model: one transaction record with its grant edge and response edge.
    bit          m_act;
    int          m_gcyc, m_rcyc, m_port, m_last;
    logic [31:0] m_addr;
    logic [63:0] m_rd [2];
    bit          m_err;

    initial begin
        m_act = 0; m_gcyc = 0; m_rcyc = -1; m_port = 0; m_last = 1;
        m_addr = 0; m_rd[0] = 0; m_rd[1] = 0; m_err = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_act = 0; m_rcyc = -1; m_last = 1; m_addr = 0;
                m_rd[0] = 0; m_rd[1] = 0; m_err = 0;
            end else begin
                if (m_act && m_rcyc >= 0 && cyc >= m_rcyc + 3) m_act = 0;
                if (m_act && m_rcyc < 0) begin
                    if (mem_ready) begin
                        m_rcyc = cyc; m_rd[m_port] = mem_rdata; m_last = m_port;
                    end else if (TO != 0 && cyc - m_gcyc == TO) begin
                        m_rcyc = cyc; m_rd[m_port] = 0; m_err = 1; m_last = m_port;
                    end
                end else if (!m_act && (req_valid[0] || req_valid[1])) begin
                    m_port = (req_valid[0] && req_valid[1]) ? 1 - m_last : (req_valid[0] ? 0 : 1);
                    m_act  = 1; m_gcyc = cyc; m_rcyc = -1;
                    m_addr = req_addr[m_port];
                end
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    initial begin
        bit prev_mv;
        int run;
        prev_mv = 0; run = 0; r1_cnt = 0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("mem_valid", mem_valid, m_act && m_rcyc < 0);
                chk("mem_addr", mem_addr, m_addr);
                chk("req0_ready", req0_ready, m_act && m_rcyc == cyc && m_port == 0);
                chk("req1_ready", req1_ready, m_act && m_rcyc == cyc && m_port == 1);
                chk("req0_rdata", req0_rdata, m_rd[0]);
                chk("req1_rdata", req1_rdata, m_rd[1]);
                chk("busy", busy, m_act && (m_rcyc < 0 || cyc < m_rcyc + 2));
                chk("err_timeout", err_timeout, m_err);
            end
            if (mem_valid === 1'b1) begin
                if (!prev_mv) gq.push_back(cyc);
                run++;
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            prev_mv = (mem_valid === 1'b1);
            if (req1_ready === 1'b1) r1_cnt++;
        end
    end

    // Memory stub and requesters
    initial begin
        int icnt;
        logic rdy;
        logic [63:0] rd;
        icnt = 0;
        mem_ready = 0; mem_rdata = 0;
        req_valid[0] = 0; req_valid[1] = 0; req_addr[0] = 0; req_addr[1] = 0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) icnt++; else icnt = 0;
            mem_ready = force_ready || (mem_valid === 1'b1 && lat != 0 && icnt == lat);
            mem_rdata = (mem_ready && !force_ready) ? line_of(mem_addr)
                                                    : (64'hDEAD_BEEF_0BAD_F00D ^ {32'(icnt), 32'(cyc)});
            for (int p = 0; p < 2; p++) begin
                rdy = (p == 0) ? req0_ready : req1_ready;
                rd  = (p == 0) ? req0_rdata : req1_rdata;
                if (kill) begin
                    req_valid[p] = 0;
                    pq[p].delete();
                end else if (req_valid[p] && rdy === 1'b1) begin
                    req_valid[p] = 0;
                    lp.push_back(p); la.push_back(req_addr[p]); ld.push_back(rd);
                end else if (!req_valid[p] && pq[p].size() > 0) begin
                    req_valid[p] = 1;
                    req_addr[p]  = pq[p].pop_front();
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (lp.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_log_done", lp.size() >= n, 1'b1);
    endtask

    task automatic clear_logs();
        lp.delete(); la.delete(); ld.delete(); runs.delete(); gq.delete();
        r1_cnt = 0;
    endtask

    function automatic int log_p(input int k);
        return (k < lp.size()) ? lp[k] : -1;
    endfunction

    function automatic logic [31:0] log_a(input int k);
        return (k < la.size()) ? la[k] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [63:0] log_d(input int k);
        return (k < ld.size()) ? ld[k] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic int q_at(input int q [$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    initial begin
        logic [31:0] tie_addr [8];
        int k;
        tie_addr = '{32'h10, 32'h40, 32'h20, 32'h44, 32'h30, 32'h48, 32'h50, 32'h4C};
        reset = 1; lat = 1; kill = 0; force_ready = 0;
        ticks(3);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_rdata0", req0_rdata, 0);
        reset = 0;
        tick();

        // Single port-0 read of line 0x00
        clear_logs();
        pq[0].push_back(32'h00);
        wait_log(1, 50);
        chk("t1_port", log_p(0), 0);
        chk("t1_addr", log_a(0), 32'h00);
        chk("t1_rdata", log_d(0), 64'hA000_0001_A000_0000);
        chk("t1_no_req1_ready", r1_cnt, 0);
        ticks(4);

        // Eight tied requests from reset: strict alternation starting at port 0
        reset = 1; lat = 2;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            pq[0].push_back(tie_addr[2*i]);
            pq[1].push_back(tie_addr[2*i+1]);
        end
        ticks(2);
        reset = 0;
        wait_log(8, 300);
        for (int i = 0; i < 8; i++) begin
            chk("tie_port", log_p(i), i % 2);
            chk("tie_addr", log_a(i), tie_addr[i]);
        end
        chk("tie_rdata_first", log_d(0), 64'hA000_0005_A000_0004);
        ticks(4);

        // Back-to-back port-0 reads with single-cycle memory
        lat = 1;
        clear_logs();
        pq[0].push_back(32'h00); pq[0].push_back(32'h08); pq[0].push_back(32'h10);
        wait_log(3, 100);
        chk("b2b_gap01", q_at(gq, 1) - q_at(gq, 0), 4);
        chk("b2b_gap12", q_at(gq, 2) - q_at(gq, 1), 4);
        chk("b2b_rdata1", log_d(1), 64'hA000_0003_A000_0002);
        ticks(4);

        // Memory never answers: watchdog abort after exactly TO cycles
        lat = 0;
        clear_logs();
        pq[0].push_back(32'h20);
        wait_log(1, 100);
        chk("to_rdata", log_d(0), 64'h0);
        ticks(3);
        chk("to_run_len", q_at(runs, 0), 8);
        chk("to_err_set", err_timeout, 1);
        lat = 1;
        pq[0].push_back(32'h28);
        wait_log(2, 50);
        chk("to_next_rdata", log_d(1), 64'hA000_000B_A000_000A);
        chk("to_err_sticky", err_timeout, 1);
        ticks(4);

        // Reset during ISSUE, followed by a stale memory response
        reset = 1;
        tick();
        reset = 0; lat = 0;
        clear_logs();
        pq[0].push_back(32'h30);
        k = 0;
        while (mem_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("rst_issue_reached", mem_valid, 1);
        tick();
        reset = 1; kill = 1;
        tick();
        reset = 0;
        tick();
        force_ready = 1;
        tick();
        force_ready = 0; kill = 0;
        ticks(4);
        chk("rst_mid_no_ready", lp.size(), 0);
        chk("rst_mid_err", err_timeout, 0);
        chk("rst_mid_mem_valid", mem_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rdata0", req0_rdata, 0);

        // Memory answers on the same edge the watchdog expires
        lat = 8;
        clear_logs();
        pq[0].push_back(32'h38);
        wait_log(1, 60);
        chk("tie_to_rdata", log_d(0), 64'hA000_000F_A000_000E);
        ticks(3);
        chk("tie_to_err", err_timeout, 0);
        chk("tie_to_run_len", q_at(runs, 0), 8);

        ticks(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_wide_arbiter.md
# imem_wide_arbiter

Two-port arbiter that shares a single wide instruction-memory port (`imem_wide`, NUM_BLOCKS×32-bit line reads) between two line-fill requesters. Port 0 is the icache refill path (`icache_Xwa_wide` mem_req_* side); port 1 is a secondary line reader such as a decompression-dictionary loader or prefetcher. The arbiter uses round-robin priority, serialises one outstanding memory transaction at a time, and has a watchdog that guarantees forward progress if memory never responds.

## Interface
- `NUM_BLOCKS`, 2: 32-bit words per line; data width is `DW = 32*NUM_BLOCKS`.
- `TIMEOUT`, 64: cycles a memory transaction may stay in ISSUE before abort; 0 disables the watchdog; counter width `$clog2(TIMEOUT+1)`, minimum 1.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid`  in  1  port 0 request; held with `req0_addr` stable until `req0_ready`.
- `req0_addr`  in  32  port 0 line address.
- `req0_ready`  out  1  one-cycle response pulse for port 0.
- `req0_rdata`  out  DW  port 0 line data, valid while `req0_ready`=1.
- `req1_valid` / `req1_addr` / `req1_ready` / `req1_rdata`: same as port 0, for port 1.
- `mem_valid`  out  1  request to `imem_wide`.
- `mem_addr`  out  32  latched address of the granted request.
- `mem_ready`  in  1  memory completion pulse.
- `mem_rdata`  in  DW  memory line data, sampled when `mem_ready`=1.
- `busy`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  sticky; set on a watchdog abort, cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, RESP, DRAIN. All outputs are registered.
- IDLE: sample `req0_valid`/`req1_valid`.
  - One valid: grant it.
  - Both valid: grant the port other than `last_grant`.
  - On grant: latch the address into `mem_addr`, latch the grant id, clear the watchdog counter, go to ISSUE.
  - `mem_ready` is ignored in IDLE.
- ISSUE: `mem_valid`=1 with `mem_addr` constant.
  - On `mem_ready`=1: latch `mem_rdata` into the granted port's rdata register, go to RESP.
  - Otherwise, if `TIMEOUT`≠0, increment the counter. When the counter reaches `TIMEOUT`, latch rdata = 0, set `err_timeout`, go to RESP.
- RESP: assert the granted `reqN_ready`=1 for exactly one cycle; `mem_valid`=0; update `last_grant` to the granted port; go to DRAIN.
- DRAIN: one cycle in which no grant is made, so the requester can drop its valid. Go to IDLE.
- Non-granted ports:
  - `reqN_ready` stays 0.
  - A requester's `reqN_rdata` holds its last value until that port's next RESP.
- Rdata is only guaranteed during `reqN_ready`.
- Requests that drop valid before being granted are not served; no requests are queued.
- Address changes by a granted requester during ISSUE are ignored, because the address was latched at grant.
- `mem_ready` pulses in RESP or DRAIN (stale or late responses) are ignored.

## Timing
- Reset values: `mem_valid`=0, `mem_addr`=0, `req0_ready`=`req1_ready`=0, `req0_rdata`=`req1_rdata`=0, `busy`=0, `err_timeout`=0, state=IDLE, `last_grant`=1 (so port 0 wins the first tie).
- Latency: request sampled in IDLE at edge t → `mem_valid` high from t+1. `mem_ready` sampled at edge k → `reqN_ready` high for cycle k+1 only → DRAIN at k+2 → IDLE at k+3. The earliest next grant is sampled at edge k+3.
- With a single-cycle memory (ready on the first ISSUE cycle): 4 cycles per transaction, from request sample to the next IDLE.
- Reset asserted mid-transaction: the next edge forces the reset values. `mem_valid` falls that cycle, and a later `mem_ready` from the aborted read is ignored.
- Reset has priority over every other event, including a simultaneous `mem_ready` or timeout.
- Timeout: `mem_valid` is high for exactly `TIMEOUT` cycles, then RESP is entered. If `mem_ready` arrives on the same edge as the timeout, it wins: data is returned and `err_timeout` is not set.

## Test plan
- Single port 0 read of 0x00 with `imem_wide` preloaded → `mem_addr`=0x00, `req0_ready` one cycle, `req0_rdata` equals the memory line words 0..1; `req1_ready` never asserts.
- `req0_valid` and `req1_valid` both asserted from reset (addr 0x10 and 0x40) → port 0 served first, then port 1. Repeat the tie → port 1 first, i.e. strict alternation over 8 tied requests.
- Back-to-back port 0 requests 0x00, 0x08, 0x10 with port 1 idle → each served; grants separated by ≥4 cycles; `busy` low only in IDLE.
- Memory stub that never asserts `mem_ready`, `TIMEOUT`=8 → `mem_valid` high exactly 8 cycles, `req0_ready` pulses with rdata 0, `err_timeout`=1 and stays set; the next request still completes normally.
- `reset` asserted during ISSUE, with the stub asserting `mem_ready` 2 cycles later → all outputs at reset values, no `reqN_ready` pulse, `err_timeout`=0.
- `mem_ready` on the same edge the counter reaches `TIMEOUT` → data returned, `err_timeout` stays 0.
